// File: rtl/div_7x3_seq.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Divide-by-zero completes in one cycle with an all-ones quotient and div_zero set.
module div_7x3_seq #(
  parameter int DVD_W = 7,
  parameter int DVS_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [DVD_W-1:0] q_r;
  // Partial remainder; its top bit is always 0 between steps (P < D), so only
  // the low DVS_W bits are stored and the shifted value carries the extra bit.
  logic [DVS_W-1:0] p_r;
  logic [DVS_W-1:0] d_r;
  logic [CNT_W-1:0] cnt;

  logic [DVS_W:0]   p_sh;
  logic [DVS_W-1:0] p_sub;
  logic             p_ge;
  logic [DVD_W-1:0] q_nxt;
  logic [DVS_W-1:0] p_nxt;

  always_comb begin
    p_sh  = {p_r, q_r[DVD_W-1]};
    p_ge  = (p_sh >= {1'b0, d_r});
    // Result is < D when p_ge, so the low bits of the difference are exact.
    p_sub = p_sh[DVS_W-1:0] - d_r;
    q_nxt = {q_r[DVD_W-2:0], p_ge};
    p_nxt = p_ge ? p_sub : p_sh[DVS_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      q_r       <= '0;
      p_r       <= '0;
      d_r       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              state     <= S_DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
              div_zero  <= 1'b1;
            end else begin
              state    <= S_RUN;
              busy     <= 1'b1;
              q_r      <= dividend;
              p_r      <= '0;
              d_r      <= divisor;
              cnt      <= CNT_W'(DVD_W - 1);
              div_zero <= 1'b0;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          q_r <= q_nxt;
          p_r <= p_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_nxt;
            remainder <= p_nxt;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_7x3_seq.sv
// Directed + exhaustive bench for div_7x3_seq; scoreboard queue of expected results
// popped on every done pulse.
module tb_div_7x3_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] dividend = '0;
  logic [2:0] divisor = '0;
  logic       busy, done, div_zero;
  logic [6:0] quotient;
  logic [2:0] remainder;

  typedef struct {
    logic [6:0] dvd;
    logic [2:0] dvs;
    logic [6:0] q;
    logic [2:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  div_7x3_seq #(.DVD_W(7), .DVS_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [6:0] a, input logic [2:0] b);
    exp_t e;
    e.dvd = a;
    e.dvs = b;
    if (b == 3'd0) begin
      e.q  = 7'h7F;
      e.r  = 3'd0;
      e.dz = 1'b1;
    end else begin
      e.q  = 7'(int'(a) / int'(b));
      e.r  = 3'(int'(a) % int'(b));
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: overlap check every cycle, scoreboard compare on each done.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      checks++;
      assert (!(busy === 1'b1 && done === 1'b1)) else begin
        failures++;
        $error("FAIL overlap busy=%b done=%b required not both high", busy, done);
      end
      if (done === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $error("FAIL unexpected_done q=%0d r=%0d dz=%b required no done", quotient, remainder, div_zero);
        end else begin
          mon_e = sb.pop_front();
          assert ({quotient, remainder, div_zero} === {mon_e.q, mon_e.r, mon_e.dz}) else begin
            failures++;
            $error("FAIL result %0d/%0d got q=%0d r=%0d dz=%b exp q=%0d r=%0d dz=%b",
                   mon_e.dvd, mon_e.dvs, quotient, remainder, div_zero, mon_e.q, mon_e.r, mon_e.dz);
          end
          if (!mon_e.dz) begin
            checks++;
            assert (int'(mon_e.dvd) == int'(quotient) * int'(mon_e.dvs) + int'(remainder)
                    && remainder < mon_e.dvs) else begin
              failures++;
              $error("FAIL invariant %0d/%0d got q=%0d r=%0d", mon_e.dvd, mon_e.dvs, quotient, remainder);
            end
          end
        end
      end
    end
  end

  // Drive a request; the following rising edge accepts it.
  task automatic issue(input logic [6:0] a, input logic [2:0] b, input bit expect_result);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (expect_result) sb.push_back(model(a, b));
    @(posedge clk); #1;
    start   = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    int lat;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cyc - acc_cyc + 1;
        break;
      end
    end
    checks++;
    assert (lat == exp_lat) else begin
      failures++;
      $error("FAIL %s latency got=%0d exp=%0d", tag, lat, exp_lat);
    end
  endtask

  task automatic check_outs(input string tag, input logic [6:0] q, input logic [2:0] r,
                            input logic dz, input logic b, input logic d);
    checks++;
    assert ({quotient, remainder, div_zero, busy, done} === {q, r, dz, b, d}) else begin
      failures++;
      $error("FAIL %s got q=%0d r=%0d dz=%b busy=%b done=%b exp q=%0d r=%0d dz=%b busy=%b done=%b",
             tag, quotient, remainder, div_zero, busy, done, q, r, dz, b, d);
    end
  endtask

  initial begin
    logic [6:0] t2_a [5] = '{7'd127, 7'd100, 7'd5, 7'd0, 7'd127};
    logic [2:0] t2_b [5] = '{3'd7, 3'd6, 3'd7, 3'd3, 3'd1};
    logic [9:0] idx;
    bit         seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic divide and single-cycle done pulse
    issue(7'd105, 3'd5, 1'b1);
    wait_done(8, "t1");
    @(negedge clk);
    check_outs("t1_hold", 7'd21, 3'd0, 1'b0, 1'b0, 1'b0);

    // Directed sweep
    for (int k = 0; k < 5; k++) begin
      issue(t2_a[k], t2_b[k], 1'b1);
      wait_done(8, "t2");
    end

    // Divide by zero
    issue(7'd42, 3'd0, 1'b1);
    wait_done(1, "t3");
    @(negedge clk);
    check_outs("t3_after", 7'h7F, 3'd0, 1'b1, 1'b0, 1'b0);

    // Start while busy is ignored; back-to-back start in the done cycle
    issue(7'd90, 3'd4, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; dividend = 7'd9; divisor = 3'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_outs("t4_run", 7'h7F, 3'd0, 1'b0, 1'b1, 1'b0);
    wait_done(8, "t4a");
    issue(7'd9, 3'd3, 1'b1);
    @(negedge clk);
    check_outs("t4_hold", 7'd22, 3'd2, 1'b0, 1'b1, 1'b0);
    wait_done(8, "t4b");

    // Reset mid-run aborts with no done pulse
    issue(7'd77, 3'd6, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_outs("t5_reset", 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    assert (!seen) else begin
      failures++;
      $error("FAIL t5_no_done got done=1 exp done=0");
    end
    issue(7'd77, 3'd6, 1'b1);
    wait_done(8, "t5");

    // All operand pairs, permuted order, issued back-to-back
    for (int i = 0; i < 1024; i++) begin
      idx = 10'((i * 397) % 1024);
      issue(idx[9:3], idx[2:0], 1'b1);
      wait_done((idx[2:0] == 3'd0) ? 1 : 8, "t6");
    end

    repeat (2) @(negedge clk);
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_empty got=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
